// File: rtl/mode_pkg.sv
// Shared definitions for the mode sequencer: the controller state encoding
// and the helper that sizes the mode index bus.
package mode_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PEND  = 2'd1,
    ST_FLUSH = 2'd2
  } seq_state_t;

  // A single mode still needs a one-bit index bus.
  function automatic int mode_width(input int num_modes);
    return (num_modes < 2) ? 1 : $clog2(num_modes);
  endfunction

endpackage

// File: rtl/mode_sequencer_if.sv
// Mode sequencer signal bundle.
//   master: drives mode_btn, dir, busy; observes the mode outputs.
//   slave : the sequencer itself.
//   mode_btn    raw mode-step button (asynchronous)
//   dir         step direction, 0 = next, 1 = previous
//   busy        downstream block mid-operation, defers a step
//   mode_idx    current mode index
//   mode_onehot one-hot enable of the current mode
//   mode_chg    one-cycle pulse when mode_idx changes
//   sub_clr     clear for downstream buffers while flushing
//   pending     a step is waiting for busy to drop
interface mode_sequencer_if #(
  parameter int NUM_MODES = 2
) ();
  import mode_pkg::*;

  localparam int MW = mode_width(NUM_MODES);

  logic                 mode_btn;
  logic                 dir;
  logic                 busy;
  logic [MW-1:0]        mode_idx;
  logic [NUM_MODES-1:0] mode_onehot;
  logic                 mode_chg;
  logic                 sub_clr;
  logic                 pending;

  modport master (
    output mode_btn, dir, busy,
    input  mode_idx, mode_onehot, mode_chg, sub_clr, pending
  );

  modport slave (
    input  mode_btn, dir, busy,
    output mode_idx, mode_onehot, mode_chg, sub_clr, pending
  );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a level debouncer.
//   clk, rst_n : system clock, asynchronous active-low reset
//   raw        : bouncing button input, asynchronous to clk
//   level      : accepted (debounced) button level
//   rise       : one-cycle pulse in the cycle level goes high
// The level flips only after the synchronised input has disagreed with it
// for DEB_CYCLES consecutive cycles; any agreeing cycle restarts the count.
module btn_debounce #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync_a;
  logic          sync_b;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
      level  <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      rise   <= 1'b0;
      if (sync_b != level) begin
        if (cnt == CNT_LAST) begin
          level <= sync_b;
          rise  <= sync_b;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/mode_sequencer.sv
// Mode sequencer: steps a mode index on each debounced button press,
// deferring the step while the active sub-block is busy and holding a
// downstream clear for FLUSH_CYCLES after every mode change.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : slave side of mode_sequencer_if (button, dir, busy in;
//                mode index/one-hot, mode_chg, sub_clr, pending out)
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | waiting for a step request
// ST_PEND  | request latched with its direction, waiting for busy=0
// ST_FLUSH | mode just changed, sub_clr held, new requests dropped
module mode_sequencer
  import mode_pkg::*;
#(
  parameter int NUM_MODES    = 2,
  parameter int DEB_CYCLES   = 20000,
  parameter int FLUSH_CYCLES = 4,
  parameter int INIT_MODE    = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  mode_sequencer_if.slave bus
);

  localparam int MW = mode_width(NUM_MODES);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [MW-1:0]        IDX_LAST   = MW'(NUM_MODES - 1);
  localparam logic [MW-1:0]        IDX_INIT   = MW'(INIT_MODE);
  localparam logic [NUM_MODES-1:0] OH_ONE     = NUM_MODES'(1);
  localparam logic [NUM_MODES-1:0] OH_INIT    = OH_ONE << INIT_MODE;
  localparam logic [FW-1:0]        FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

  seq_state_t           state_q, state_d;
  logic [MW-1:0]        idx_q, idx_d;
  logic [NUM_MODES-1:0] oh_q, oh_d;
  logic                 chg_q, chg_d;
  logic                 clr_q, clr_d;
  logic                 pend_q, pend_d;
  logic                 pdir_q, pdir_d;
  logic [FW-1:0]        fcnt_q, fcnt_d;
  logic                 btn_level;
  logic                 btn_rise;
  logic                 step_req;
  logic                 step_go;
  logic                 step_dir;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (bus.mode_btn),
    .level(btn_level),
    .rise (btn_rise)
  );

  // rise only ever fires together with the newly accepted high level.
  assign step_req = btn_rise & btn_level;

  function automatic logic [MW-1:0] stepped(input logic [MW-1:0] cur,
                                            input logic back);
    if (back) return (cur == '0) ? IDX_LAST : cur - MW'(1);
    return (cur == IDX_LAST) ? '0 : cur + MW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_INIT;
      oh_q    <= OH_INIT;
      chg_q   <= 1'b0;
      clr_q   <= 1'b1;
      pend_q  <= 1'b0;
      pdir_q  <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      chg_q   <= chg_d;
      clr_q   <= clr_d;
      pend_q  <= pend_d;
      pdir_q  <= pdir_d;
      fcnt_q  <= fcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    oh_d     = oh_q;
    chg_d    = 1'b0;
    clr_d    = clr_q;
    pend_d   = pend_q;
    pdir_d   = pdir_q;
    fcnt_d   = fcnt_q;
    step_go  = 1'b0;
    step_dir = bus.dir;

    case (state_q)
      ST_IDLE: begin
        // Also releases the clear held through reset.
        clr_d = 1'b0;
        if (step_req) begin
          if (!bus.busy) begin
            step_go = 1'b1;
          end else begin
            pdir_d  = bus.dir;
            pend_d  = 1'b1;
            state_d = ST_PEND;
          end
        end
      end
      ST_PEND: begin
        if (!bus.busy) begin
          step_go  = 1'b1;
          step_dir = pdir_q;
          pend_d   = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (fcnt_q == '0) begin
          clr_d   = 1'b0;
          state_d = ST_IDLE;
        end else begin
          fcnt_d = fcnt_q - FW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (step_go) begin
      idx_d   = stepped(idx_q, step_dir);
      oh_d    = OH_ONE << idx_d;
      chg_d   = 1'b1;
      clr_d   = 1'b1;
      fcnt_d  = FLUSH_LOAD;
      state_d = ST_FLUSH;
    end
  end

  assign bus.mode_idx    = idx_q;
  assign bus.mode_onehot = oh_q;
  assign bus.mode_chg    = chg_q;
  assign bus.sub_clr     = clr_q;
  assign bus.pending     = pend_q;

endmodule

// File: doc/mode_sequencer.md
MODE_SEQUENCER -- requirements
Module: mode_sequencer

Interface
REQ-001 Parameter NUM_MODES, 2, number of operating modes (>=2, need not be a power of two).
REQ-002 Parameter DEB_CYCLES, 20000, clock cycles a synchronised button level must hold before it is accepted.
REQ-003 Parameter FLUSH_CYCLES, 4, cycles sub_clr is held after a mode change (>=1).
REQ-004 Parameter INIT_MODE, 0, mode index loaded at reset (< NUM_MODES).
REQ-005 Port clk  input  1  the single system clock.
REQ-006 Port rst_n  input  1  reset; asynchronous, active-low.
REQ-007 Port mode_btn  input  1  raw, bouncing mode-step button, asynchronous to clk.
REQ-008 Port dir  input  1  step direction, sampled at the step request: 0 = next, 1 = previous.
REQ-009 Port busy  input  1  active sub-block mid-operation; defers a mode change.
REQ-010 Port mode_idx  output  MW  current mode index, MW = max(1, clog2(NUM_MODES)).
REQ-011 Port mode_onehot  output  NUM_MODES  one-hot enable of the current mode.
REQ-012 Port mode_chg  output  1  one-cycle pulse in the cycle mode_idx takes a new value.
REQ-013 Port sub_clr  output  1  clear for downstream encoder/decoder buffers during flush.
REQ-014 Port pending  output  1  a step request is waiting for busy to drop.

Function
REQ-015 mode_btn SHALL pass through a 2-flop synchroniser before debouncing.
REQ-016 The debounced level SHALL change only after the synchronised input has differed from it for DEB_CYCLES consecutive cycles; any interruption restarts the count.
REQ-017 A rising edge of the debounced level SHALL produce a one-cycle step request; falling edges produce none.
REQ-018 The FSM SHALL have states IDLE, PEND and FLUSH.
REQ-019 IDLE, request, busy=0: next cycle mode_idx updates, mode_chg=1, sub_clr=1, state->FLUSH.
REQ-020 IDLE, request, busy=1: latch dir, pending=1, state->PEND.
REQ-021 PEND: in the first cycle busy=0, apply the latched direction as in REQ-019 and clear pending.
REQ-022 FLUSH: sub_clr SHALL stay high exactly FLUSH_CYCLES cycles, counted from the mode_chg cycle, then state->IDLE.
REQ-023 Requests arriving in PEND or FLUSH SHALL be dropped and not queued.
REQ-024 Forward step SHALL wrap NUM_MODES-1 -> 0; backward step SHALL wrap 0 -> NUM_MODES-1; indices >= NUM_MODES SHALL never appear.
REQ-025 mode_onehot SHALL always equal 1 << mode_idx, registered in the same cycle as mode_idx.
REQ-026 busy SHALL be ignored outside IDLE and PEND; busy rising during FLUSH does not shorten the flush.
REQ-027 A request coinciding with the last FLUSH cycle SHALL be dropped.

Reset
REQ-028 While rst_n=0: mode_idx=INIT_MODE, mode_onehot=1<<INIT_MODE, mode_chg=0, sub_clr=1, pending=0, state=IDLE, synchroniser and debounced level=0, counters=0.
REQ-029 Reset assertion mid-PEND or mid-FLUSH SHALL discard the request and counters immediately.
REQ-030 sub_clr SHALL drop in the first clock edge after rst_n deasserts; no mode_chg pulse is emitted on reset exit.

Structure
REQ-031 A shared package mode_pkg SHALL hold the FSM state enum and a width helper for MW.
REQ-032 Synchroniser and debounce SHALL be a sub-module btn_debounce (params DEB_CYCLES; ports clk, rst_n, raw, level, rise).
REQ-033 The debounce counter width SHALL be clog2(DEB_CYCLES+1); the flush counter width clog2(FLUSH_CYCLES+1).

Verification (NUM_MODES=3, DEB_CYCLES=4, FLUSH_CYCLES=2, INIT_MODE=0)
REQ-034 Reset release -> mode_idx=0, mode_onehot=3'b001, sub_clr low after first edge, no mode_chg.
REQ-035 Clean press, dir=0, busy=0, three times -> mode_idx 1,2,0 (wrap), one mode_chg each, sub_clr high 2 cycles each.
REQ-036 Bounce pattern high 3 / low 1 / high 3 cycles -> no request; held high 4+ cycles -> exactly one step.
REQ-037 From mode 0, press with dir=1 -> mode_idx=2, mode_onehot=3'b100.
REQ-038 Press with busy=1 for 10 cycles -> pending=1, mode_idx unchanged; busy falls -> next cycle mode_idx steps, pending=0; second press during PEND -> dropped (single step only).
REQ-039 rst_n pulsed low during FLUSH from mode 1 -> mode_idx=0, pending=0, sub_clr=1 until release, no further step.
